rv32i_writeback_unit: RTL and testbench

- Final pipeline stage of the RV32I core. It sits directly upstream of the register file and is the only driver of its write port (indata, rd, we).
- Accepts one retiring instruction at a time: either an ALU result, or a load whose address is in in_result.
- For loads it runs a single-outstanding memory read handshake, then extracts the addressed byte, halfword or word and sign- or zero-extends it.
- Produces a one-cycle registered write pulse to the register file.

---
 rtl/rv32i_pkg.sv | 30 +++
 rtl/rv32i_writeback_unit_if.sv | 44 ++++
 rtl/rv32i_load_align.sv | 33 +++
 rtl/rv32i_writeback_unit.sv | 130 +++++++++++++
 tb/tb_rv32i_writeback_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared constants for the RV32I writeback stage.
// Load funct3 codes, state encoding and the misalignment rule.
package rv32i_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_MEM   = 2'd1,
        WB_WRITE = 2'd2
    } wb_state_e;

`ifdef RV32_WB_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(
        input logic [2:0] f3,
        input logic [1:0] lane
    );
        case (f3)
            F3_LB, F3_LBU: return 1'b0;
            F3_LH, F3_LHU: return lane[0];
            default:       return lane != 2'b00;
        endcase
    endfunction
`endif

endpackage

// File: rtl/rv32i_writeback_unit_if.sv
// rv32i_writeback_unit_if: retire, memory-read and register-file
// signals of the writeback stage (misalign only with RV32_WB_MISALIGN_TRAP_EN).
interface rv32i_writeback_unit_if;

    logic        in_valid;
    logic        in_ready;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_indata;
    logic        busy;
    logic        timeout;
`ifdef RV32_WB_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    modport slave (
        input  in_valid, in_is_load, in_funct3, in_rd, in_result,
        input  mem_ack, mem_rdata,
        output in_ready, mem_req, mem_addr,
        output rf_we, rf_rd, rf_indata, busy, timeout
`ifdef RV32_WB_MISALIGN_TRAP_EN
        , output misalign
`endif
    );

    modport master (
        output in_valid, in_is_load, in_funct3, in_rd, in_result,
        output mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_addr,
        input  rf_we, rf_rd, rf_indata, busy, timeout
`ifdef RV32_WB_MISALIGN_TRAP_EN
        , input misalign
`endif
    );

endinterface

// File: rtl/rv32i_load_align.sv
// rv32i_load_align: picks the addressed byte/halfword/word out of a
// little-endian read word and sign- or zero-extends it.
module rv32i_load_align
    import rv32i_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select, then extend by width and signedness.
    always_comb begin
        unique case (lane_i)
            2'd0: byte_v = word_i[7:0];
            2'd1: byte_v = word_i[15:8];
            2'd2: byte_v = word_i[23:16];
            2'd3: byte_v = word_i[31:24];
        endcase
        half_v = lane_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_v[7]}}, byte_v};
            F3_LBU:  data_o = {24'd0, byte_v};
            F3_LH:   data_o = {{16{half_v[15]}}, half_v};
            F3_LHU:  data_o = {16'd0, half_v};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/rv32i_writeback_unit.sv
// rv32i_writeback_unit: final RV32I stage, sole writer of the register file.
// Optional macro RV32_WB_MISALIGN_TRAP_EN traps misaligned loads.
module rv32i_writeback_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned TMO_W       = 8
) (
    input logic                   sys_clk,
    input logic                   sys_reset,
    rv32i_writeback_unit_if.slave wb
);

    localparam bit TMO_EN = (MEM_TIMEOUT != 0);
    localparam int unsigned TMO_LAST_I = TMO_EN ? MEM_TIMEOUT - 1 : 0;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LAST_I);

    wb_state_e         state_q;
    logic              mem_req_q;
    logic [31:0]       mem_addr_q;
    logic [1:0]        lane_q;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              rf_we_q;
    logic [4:0]        rf_rd_q;
    logic [31:0]       rf_indata_q;
    logic              timeout_q;
    logic [TMO_W-1:0]  cnt_q;
    logic [31:0]       load_val;
    logic              xfer;
`ifdef RV32_WB_MISALIGN_TRAP_EN
    logic              misalign_q;
    logic              mis_in;

    assign mis_in = is_misaligned(wb.in_funct3, wb.in_result[1:0]);
`endif

    assign xfer = wb.in_valid && (state_q == WB_IDLE);

    rv32i_load_align u_align (
        .word_i   (wb.mem_rdata),
        .lane_i   (lane_q),
        .funct3_i (f3_q),
        .data_o   (load_val)
    );

    // Sequencer IDLE -> (MEM ->) WRITE -> IDLE with registered outputs.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q     <= WB_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            lane_q      <= '0;
            f3_q        <= '0;
            rd_q        <= '0;
            rf_we_q     <= 1'b0;
            rf_rd_q     <= '0;
            rf_indata_q <= '0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
`ifdef RV32_WB_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            rf_we_q   <= 1'b0;
            timeout_q <= 1'b0;
`ifdef RV32_WB_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            unique case (state_q)
                WB_IDLE: begin
                    if (xfer) begin
                        rd_q   <= wb.in_rd;
                        f3_q   <= wb.in_funct3;
                        lane_q <= wb.in_result[1:0];
                        cnt_q  <= '0;
                        if (!wb.in_is_load) begin
                            rf_rd_q     <= wb.in_rd;
                            rf_indata_q <= wb.in_result;
                            rf_we_q     <= wb.in_rd != 5'd0;
                            state_q     <= WB_WRITE;
                        end
`ifdef RV32_WB_MISALIGN_TRAP_EN
                        else if (mis_in) begin
                            misalign_q <= 1'b1;
                            state_q    <= WB_WRITE;
                        end
`endif
                        else begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= {wb.in_result[31:2], 2'b00};
                            state_q    <= WB_MEM;
                        end
                    end
                end
                WB_MEM: begin
                    if (wb.mem_ack) begin
                        mem_req_q   <= 1'b0;
                        rf_rd_q     <= rd_q;
                        rf_indata_q <= load_val;
                        rf_we_q     <= rd_q != 5'd0;
                        state_q     <= WB_WRITE;
                    end else if (TMO_EN && cnt_q == TMO_LAST) begin
                        mem_req_q <= 1'b0;
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= WB_IDLE;
                    end else if (TMO_EN) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WB_WRITE: state_q <= WB_IDLE;
                default:  state_q <= WB_IDLE;
            endcase
        end
    end

    assign wb.in_ready  = (state_q == WB_IDLE);
    assign wb.busy      = (state_q != WB_IDLE);
    assign wb.mem_req   = mem_req_q;
    assign wb.mem_addr  = mem_addr_q;
    assign wb.rf_we     = rf_we_q;
    assign wb.rf_rd     = rf_rd_q;
    assign wb.rf_indata = rf_indata_q;
    assign wb.timeout   = timeout_q;
`ifdef RV32_WB_MISALIGN_TRAP_EN
    assign wb.misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_rv32i_writeback_unit.sv
// tb_rv32i_writeback_unit: randomized and directed checks of the
// writeback stage against a byte-arithmetic reference model.
module tb_rv32i_writeback_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    rv32i_writeback_unit_if wbi ();
    rv32i_writeback_unit_if wbt ();

    rv32i_writeback_unit #(.MEM_TIMEOUT(0), .TMO_W(8)) dut0 (
        .sys_clk   (clk),
        .sys_reset (rst),
        .wb        (wbi)
    );

    rv32i_writeback_unit #(.MEM_TIMEOUT(3), .TMO_W(8)) dut1 (
        .sys_clk   (clk),
        .sys_reset (rst),
        .wb        (wbt)
    );

    // Reference: value written for a load, from plain shifts and masks.
    function automatic logic [31:0] ref_load(
        input logic [31:0] word,
        input logic [31:0] addr,
        input logic [2:0]  f3
    );
        int unsigned lane;
        int unsigned b;
        int unsigned h;
        lane = addr % 4;
        b = (word >> (8 * lane)) & 255;
        h = (word >> (16 * (lane / 2))) & 65535;
        case (f3)
            3'd0:    return (b < 128) ? b : b + 32'hFFFF_FF00;
            3'd4:    return b;
            3'd1:    return (h < 32768) ? h : h + 32'hFFFF_0000;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

`ifdef RV32_WB_MISALIGN_TRAP_EN
    function automatic bit ref_mis(
        input logic [2:0]  f3,
        input logic [31:0] addr
    );
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
        if (f3 == 3'd1 || f3 == 3'd5) return (addr % 2) != 0;
        return (addr % 4) != 0;
    endfunction
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wbi.in_valid = 0; wbi.in_is_load = 0; wbi.in_funct3 = 0;
        wbi.in_rd = 0; wbi.in_result = 0;
        wbi.mem_ack = 0; wbi.mem_rdata = 0;
        wbt.in_valid = 0; wbt.in_is_load = 0; wbt.in_funct3 = 0;
        wbt.in_rd = 0; wbt.in_result = 0;
        wbt.mem_ack = 0; wbt.mem_rdata = 0;
    endtask

    // One retire on dut0; n_mem = MEM cycles incl. the ack cycle.
    task automatic run_op(
        input bit          ld,
        input logic [2:0]  f3,
        input logic [4:0]  rd,
        input logic [31:0] res,
        input logic [31:0] rdata,
        input int          n_mem,
        input string       tag
    );
        logic [31:0] exp_d;
        logic [31:0] a_exp;
        bit          mis;
        bit          exp_we;
        mis = 1'b0;
`ifdef RV32_WB_MISALIGN_TRAP_EN
        if (ld) mis = ref_mis(f3, res);
`endif
        exp_d  = ld ? ref_load(rdata, res, f3) : res;
        exp_we = (rd != 0) && !mis;
        a_exp  = res - (res % 4);

        n_cmp++;
        if (wbi.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready_pre: got %b want 1", tag, wbi.in_ready);
        end
        wbi.in_valid = 1; wbi.in_is_load = ld; wbi.in_funct3 = f3;
        wbi.in_rd = rd; wbi.in_result = res;
        tick();
        wbi.in_valid = 0;
        wbi.in_is_load = 1'($urandom);
        wbi.in_funct3 = 3'($urandom);
        wbi.in_rd = 5'($urandom);
        wbi.in_result = $urandom;

        if (ld && !mis) begin
            for (int k = 1; k <= n_mem; k++) begin
                n_cmp++;
                if ({wbi.mem_req, wbi.mem_addr, wbi.rf_we, wbi.in_ready,
                     wbi.busy, wbi.timeout} !==
                    {1'b1, a_exp, 1'b0, 1'b0, 1'b1, 1'b0}) begin
                    n_bad++;
                    $display("FAIL %s mem%0d: got req=%b addr=%h we=%b rdy=%b busy=%b tmo=%b want req=1 addr=%h we=0 rdy=0 busy=1 tmo=0",
                             tag, k, wbi.mem_req, wbi.mem_addr, wbi.rf_we,
                             wbi.in_ready, wbi.busy, wbi.timeout, a_exp);
                end
                wbi.mem_ack = (k == n_mem);
                wbi.mem_rdata = (k == n_mem) ? rdata : $urandom;
                tick();
            end
            wbi.mem_ack = 0;
        end

        n_cmp++;
        if ({wbi.rf_we, wbi.in_ready, wbi.busy, wbi.mem_req} !==
            {exp_we, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL %s write: got we/rdy/busy/req=%b%b%b%b want %b010",
                     tag, wbi.rf_we, wbi.in_ready, wbi.busy, wbi.mem_req,
                     exp_we);
        end
        if (exp_we) begin
            n_cmp++;
            if ({wbi.rf_rd, wbi.rf_indata} !== {rd, exp_d}) begin
                n_bad++;
                $display("FAIL %s data: got rd=%0d data=%h want rd=%0d data=%h",
                         tag, wbi.rf_rd, wbi.rf_indata, rd, exp_d);
            end
        end
`ifdef RV32_WB_MISALIGN_TRAP_EN
        n_cmp++;
        if (wbi.misalign !== mis) begin
            n_bad++;
            $display("FAIL %s misalign: got %b want %b", tag, wbi.misalign, mis);
        end
`endif
        tick();
        n_cmp++;
        if ({wbi.rf_we, wbi.in_ready, wbi.busy, wbi.mem_req} !== 4'b0100) begin
            n_bad++;
            $display("FAIL %s after: got we/rdy/busy/req=%b%b%b%b want 0100",
                     tag, wbi.rf_we, wbi.in_ready, wbi.busy, wbi.mem_req);
        end
        if (exp_we) begin
            n_cmp++;
            if ({wbi.rf_rd, wbi.rf_indata} !== {rd, exp_d}) begin
                n_bad++;
                $display("FAIL %s hold: got rd=%0d data=%h want rd=%0d data=%h",
                         tag, wbi.rf_rd, wbi.rf_indata, rd, exp_d);
            end
        end
`ifdef RV32_WB_MISALIGN_TRAP_EN
        n_cmp++;
        if (wbi.misalign !== 1'b0) begin
            n_bad++;
            $display("FAIL %s misalign_end: got %b want 0", tag, wbi.misalign);
        end
`endif
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (3) tick();
        n_cmp++;
        if ({wbi.mem_req, wbi.mem_addr, wbi.rf_we, wbi.rf_rd, wbi.rf_indata,
             wbi.timeout, wbi.busy, wbi.in_ready} !== {72'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset0: got req=%b addr=%h we=%b rd=%0d data=%h tmo=%b busy=%b rdy=%b want all 0 rdy=1",
                     wbi.mem_req, wbi.mem_addr, wbi.rf_we, wbi.rf_rd,
                     wbi.rf_indata, wbi.timeout, wbi.busy, wbi.in_ready);
        end
        n_cmp++;
        if ({wbt.mem_req, wbt.rf_we, wbt.timeout, wbt.busy, wbt.in_ready}
            !== 5'b00001) begin
            n_bad++;
            $display("FAIL reset1: got req/we/tmo/busy/rdy=%b%b%b%b%b want 00001",
                     wbt.mem_req, wbt.rf_we, wbt.timeout, wbt.busy, wbt.in_ready);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_alu();
        run_op(0, 3'd0, 5'd5, 32'hDEAD_BEEF, 32'd0, 1, "alu_rd5");
        run_op(0, 3'd0, 5'd31, 32'h0000_0001, 32'd0, 1, "alu_rd31");
        run_op(0, 3'd0, 5'd0, 32'h1234_5678, 32'd0, 1, "alu_rd0");
    endtask

    task automatic test_load_extract();
        run_op(1, 3'b000, 5'd3, 32'h1003, 32'h80FF_1234, 1, "lb");
        run_op(1, 3'b100, 5'd4, 32'h1003, 32'h80FF_1234, 1, "lbu");
        run_op(1, 3'b101, 5'd6, 32'h1002, 32'h80FF_1234, 1, "lhu");
        run_op(1, 3'b001, 5'd7, 32'h1002, 32'h80FF_1234, 1, "lh");
        run_op(1, 3'b010, 5'd8, 32'h1000, 32'h80FF_1234, 1, "lw");
        run_op(1, 3'b111, 5'd9, 32'h1000, 32'hCAFE_F00D, 1, "f3_111");
    endtask

    task automatic test_wait_states();
        run_op(1, 3'b010, 5'd10, 32'h2004, 32'hA5A5_0F0F, 4, "wait4");
        run_op(1, 3'b000, 5'd11, 32'h2001, 32'h0000_7F00, 12, "wait12");
    endtask

    task automatic test_rd_zero();
        run_op(1, 3'b010, 5'd0, 32'h3000, 32'hFFFF_FFFF, 2, "ld_rd0");
    endtask

    task automatic test_ack_in_idle();
        for (int k = 0; k < 3; k++) begin
            wbi.mem_ack = 1;
            wbi.mem_rdata = $urandom;
            tick();
            n_cmp++;
            if ({wbi.rf_we, wbi.busy, wbi.mem_req, wbi.in_ready} !== 4'b0001) begin
                n_bad++;
                $display("FAIL idle_ack: got we/busy/req/rdy=%b%b%b%b want 0001",
                         wbi.rf_we, wbi.busy, wbi.mem_req, wbi.in_ready);
            end
        end
        wbi.mem_ack = 0;
    endtask

    task automatic test_reset_mid_load();
        wbi.in_valid = 1; wbi.in_is_load = 1; wbi.in_funct3 = 3'b010;
        wbi.in_rd = 5'd9; wbi.in_result = 32'h0000_3000;
        tick();
        wbi.in_valid = 0;
        tick();
        #2 rst = 1;
        #1;
        n_cmp++;
        if ({wbi.mem_req, wbi.rf_we, wbi.in_ready, wbi.busy, wbi.mem_addr,
             wbi.rf_indata} !== {4'b0010, 64'd0}) begin
            n_bad++;
            $display("FAIL rst_mid: got req/we/rdy/busy=%b%b%b%b addr=%h data=%h want 0010 0 0",
                     wbi.mem_req, wbi.rf_we, wbi.in_ready, wbi.busy,
                     wbi.mem_addr, wbi.rf_indata);
        end
        tick();
        rst = 0;
        wbi.mem_ack = 1;
        wbi.mem_rdata = 32'h5555_AAAA;
        tick();
        wbi.mem_ack = 0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({wbi.rf_we, wbi.busy, wbi.mem_req, wbi.in_ready} !== 4'b0001) begin
                n_bad++;
                $display("FAIL rst_late_ack: got we/busy/req/rdy=%b%b%b%b want 0001",
                         wbi.rf_we, wbi.busy, wbi.mem_req, wbi.in_ready);
            end
            tick();
        end
        run_op(1, 3'b101, 5'd12, 32'h3002, 32'h8001_0002, 1, "post_rst");
    endtask

    task automatic test_timeout();
        wbt.in_valid = 1; wbt.in_is_load = 1; wbt.in_funct3 = 3'b010;
        wbt.in_rd = 5'd7; wbt.in_result = 32'h2000;
        tick();
        wbt.in_valid = 0;
        for (int k = 1; k <= 3; k++) begin
            n_cmp++;
            if ({wbt.mem_req, wbt.timeout, wbt.busy, wbt.in_ready} !== 4'b1010) begin
                n_bad++;
                $display("FAIL tmo_mem%0d: got req/tmo/busy/rdy=%b%b%b%b want 1010",
                         k, wbt.mem_req, wbt.timeout, wbt.busy, wbt.in_ready);
            end
            tick();
        end
        n_cmp++;
        if ({wbt.mem_req, wbt.timeout, wbt.rf_we, wbt.busy, wbt.in_ready}
            !== 5'b01001) begin
            n_bad++;
            $display("FAIL tmo_fire: got req/tmo/we/busy/rdy=%b%b%b%b%b want 01001",
                     wbt.mem_req, wbt.timeout, wbt.rf_we, wbt.busy, wbt.in_ready);
        end
        tick();
        n_cmp++;
        if ({wbt.timeout, wbt.rf_we, wbt.in_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL tmo_after: got tmo/we/rdy=%b%b%b want 001",
                     wbt.timeout, wbt.rf_we, wbt.in_ready);
        end
        wbt.in_valid = 1; wbt.in_rd = 5'd8; wbt.in_result = 32'h2008;
        tick();
        wbt.in_valid = 0;
        tick();
        tick();
        wbt.mem_ack = 1;
        wbt.mem_rdata = 32'h1234_5678;
        tick();
        wbt.mem_ack = 0;
        n_cmp++;
        if ({wbt.rf_we, wbt.timeout, wbt.rf_rd, wbt.rf_indata} !==
            {2'b10, 5'd8, 32'h1234_5678}) begin
            n_bad++;
            $display("FAIL tmo_ack_wins: got we=%b tmo=%b rd=%0d data=%h want 1 0 8 12345678",
                     wbt.rf_we, wbt.timeout, wbt.rf_rd, wbt.rf_indata);
        end
        tick();
        n_cmp++;
        if ({wbt.timeout, wbt.rf_we, wbt.in_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL tmo_ack_end: got tmo/we/rdy=%b%b%b want 001",
                     wbt.timeout, wbt.rf_we, wbt.in_ready);
        end
    endtask

`ifdef RV32_WB_MISALIGN_TRAP_EN
    task automatic test_misalign();
        run_op(1, 3'b010, 5'd13, 32'h1001, 32'h1111_2222, 1, "mis_lw");
        run_op(1, 3'b001, 5'd14, 32'h1003, 32'h1111_2222, 1, "mis_lh");
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom), 3'($urandom), 5'($urandom), $urandom,
                   $urandom, int'($urandom_range(1, 4)), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_extract();
        test_wait_states();
        test_rd_zero();
        test_ack_in_idle();
        test_reset_mid_load();
        test_timeout();
`ifdef RV32_WB_MISALIGN_TRAP_EN
        test_misalign();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
